// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
//   Front end for the 12-hour BCD clock core. Produces the once-per-second
//   tick enable and runs a two-button (mode / increment) time-set machine
//   that edits a shadow copy of hours, minutes and AM/PM. On commit, it
//   issues a one-cycle load strobe back into the core.
//
// Parameters
//   TICK_DIV  clock cycles per tick_ena pulse (>= 2)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   btn_mode  in   debounced mode button (level, clk-synchronous)
//   btn_inc   in   debounced increment button (level, clk-synchronous)
//   cur_hh    in   core hours, BCD 01..12
//   cur_mm    in   core minutes, BCD 00..59
//   cur_pm    in   core PM flag
//   tick_ena  out  one-cycle enable pulse to the core (RUN only)
//   load      out  one-cycle load strobe (COMMIT cycle)
//   load_hh   out  shadow hours, BCD
//   load_mm   out  shadow minutes, BCD
//   load_pm   out  shadow PM flag
//   mode      out  0 RUN, 1 SET_HH, 2 SET_MM, 3 COMMIT
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic       cur_pm,
    output logic       tick_ena,
    output logic       load,
    output logic [7:0] load_hh,
    output logic [7:0] load_mm,
    output logic       load_pm,
    output logic [1:0] mode
);

    localparam int             CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [7:0]       hh_q, hh_d;
    logic [7:0]       mm_q, mm_d;
    logic             pm_q, pm_d;
    logic             prev_mode_q, prev_inc_q;
    logic             mode_edge, inc_edge;

    function automatic logic hh_is_valid(input logic [7:0] hh);
        return ((hh[7:4] == 4'h0) && (hh[3:0] >= 4'h1) && (hh[3:0] <= 4'h9)) ||
               (hh == 8'h10) || (hh == 8'h11) || (hh == 8'h12);
    endfunction

    function automatic logic mm_is_valid(input logic [7:0] mm);
        return (mm[7:4] <= 4'h5) && (mm[3:0] <= 4'h9);
    endfunction

    // 01..09 -> 10 -> 11 -> 12 -> 01
    function automatic logic [7:0] hh_inc(input logic [7:0] hh);
        if (hh == 8'h12)
            return 8'h01;
        else if (hh[3:0] == 4'h9)
            return 8'h10;
        else
            return hh + 8'h01;
    endfunction

    // 00..59, wraps without carry
    function automatic logic [7:0] mm_inc(input logic [7:0] mm);
        if (mm == 8'h59)
            return 8'h00;
        else if (mm[3:0] == 4'h9)
            return {mm[7:4] + 4'h1, 4'h0};
        else
            return mm + 8'h01;
    endfunction

    // Mode edge has priority: a simultaneous inc edge is dropped.
    assign mode_edge = btn_mode & ~prev_mode_q;
    assign inc_edge  = btn_inc & ~prev_inc_q & ~mode_edge;

    always_comb begin
        state_d = state_q;
        presc_d = '0;
        hh_d    = hh_q;
        mm_d    = mm_q;
        pm_d    = pm_q;
        case (state_q)
            RUN: begin
                presc_d = (presc_q == TERM) ? '0 : presc_q + CNT_W'(1);
                if (mode_edge) begin
                    state_d = SET_HH;
                    hh_d    = hh_is_valid(cur_hh) ? cur_hh : 8'h12;
                    mm_d    = mm_is_valid(cur_mm) ? cur_mm : 8'h00;
                    pm_d    = cur_pm;
                end
            end
            SET_HH: begin
                if (mode_edge) begin
                    state_d = SET_MM;
                end else if (inc_edge) begin
                    hh_d = hh_inc(hh_q);
                    // Only 11 -> 12 crosses noon/midnight.
                    if (hh_q == 8'h11)
                        pm_d = ~pm_q;
                end
            end
            SET_MM: begin
                if (mode_edge)
                    state_d = COMMIT;
                else if (inc_edge)
                    mm_d = mm_inc(mm_q);
            end
            COMMIT: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            presc_q     <= '0;
            hh_q        <= 8'h12;
            mm_q        <= 8'h00;
            pm_q        <= 1'b0;
            // Start high so a button held through reset release is not an edge.
            prev_mode_q <= 1'b1;
            prev_inc_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            pm_q        <= pm_d;
            prev_mode_q <= btn_mode;
            prev_inc_q  <= btn_inc;
        end
    end

    // Outputs decode registers only; no input-to-output paths.
    assign tick_ena = (state_q == RUN) && (presc_q == TERM);
    assign load     = (state_q == COMMIT);
    assign load_hh  = hh_q;
    assign load_mm  = mm_q;
    assign load_pm  = pm_q;
    assign mode     = state_q;

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Front-end controller for the 12-hour BCD clock core. Generates the once-per-second `tick_ena` that advances the core, and runs a two-button time-set state machine (mode/increment) that edits a shadow copy of hours, minutes and AM/PM. On commit, it issues a single-cycle load command back into the core. It sits between the debounced board buttons and the clock core's enable/load inputs.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per `tick_ena` pulse; legal range is ≥ 2.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `btn_mode` in 1: mode button, debounced and synchronous to `clk`, level.
- `btn_inc` in 1: increment button, debounced and synchronous to `clk`, level.
- `cur_hh` in 8: core hours, BCD 01..12.
- `cur_mm` in 8: core minutes, BCD 00..59.
- `cur_pm` in 1: core PM flag.
- `tick_ena` out 1: one-cycle enable pulse to the core.
- `load` out 1: one-cycle load strobe to the core.
- `load_hh` out 8: BCD hours to load.
- `load_mm` out 8: BCD minutes to load.
- `load_pm` out 1: PM value to load (seconds are always loaded as 00).
- `mode` out 2: current mode; 0 = RUN, 1 = SET_HH, 2 = SET_MM, 3 = COMMIT.

## Operation
- **Edge detect:** each button has a registered previous sample. An edge is `btn & ~prev`.
  - `prev` resets to 1, so a button held through reset release produces no edge.
  - Holding a button gives exactly one edge.
- **FSM states:** RUN, SET_HH, SET_MM, COMMIT.
  - RUN + mode edge → SET_HH. Capture shadow hh/mm/pm from `cur_*`.
    - A captured hh outside 01..12 (or with a non-BCD nibble) becomes 12.
    - A captured mm outside 00..59 becomes 00.
  - SET_HH + inc edge: shadow hh increments in BCD 01→…→09→10→11→12→01.
    - The 11→12 step toggles shadow pm.
    - The 12→01 step leaves pm unchanged.
  - SET_HH + mode edge → SET_MM.
  - SET_MM + inc edge: shadow mm increments in BCD 00..59; 59→00 wraps with no carry into hh.
  - SET_MM + mode edge → COMMIT.
  - COMMIT → RUN unconditionally after one cycle.
- **Simultaneous edges:** when mode and inc edges occur in the same cycle, the mode edge wins and the inc edge is discarded.
- **inc in RUN or COMMIT:** ignored.
- **Prescaler:** counts 0..TICK_DIV-1 in RUN only.
  - `tick_ena`=1 in the cycle the count equals TICK_DIV-1; the count then returns to 0.
  - The prescaler is held at 0 in SET_HH, SET_MM and COMMIT, and `tick_ena` is 0 in those states.
- **Load path:**
  - `load`=1 only during the COMMIT cycle.
  - `load_hh`/`load_mm`/`load_pm` equal the shadow registers at all times and are stable during `load`.
- The core is frozen while in SET states, because `tick_ena` is 0.

## Timing
- **Reset values (async on `reset`=0):**
  - State RUN; `mode`=0; `tick_ena`=0; `load`=0.
  - Shadow hh=8'h12, mm=8'h00, pm=0; so `load_hh`=8'h12, `load_mm`=8'h00, `load_pm`=0.
  - Prescaler 0; both `prev`=1.
- All outputs are registered; there are no combinational input→output paths.
- **Button latency:** a button sampled high at edge n (low at edge n-1) changes state/shadow at edge n. The new `mode`/`load_*` values are visible after edge n.
- **Commit latency:** third mode edge at edge n → `load`=1 for the cycle after edge n → RUN after edge n+1.
- **First tick after commit:** the prescaler restarts from 0 in the first RUN cycle, so the first `tick_ena` is TICK_DIV cycles after the `load` cycle.
- **First tick out of reset:** the first `tick_ena` is high in RUN cycle index TICK_DIV-1 after reset release.
- **Reset mid-set:** the shadow edit is lost, no `load` is issued, and operation returns to RUN with reset values.

## Test plan
- **Tick rate:** TICK_DIV=4, no buttons → `tick_ena` high on cycles 3, 7, 11 after reset release, single-cycle each, `load` never asserted.
- **Hour wrap/PM:** with cur=11:30 AM (`cur_hh`=8'h11, `cur_mm`=8'h30, `cur_pm`=0), press mode, then inc ×2.
  - After the first inc: shadow hh=8'h12, pm=1.
  - After the second inc: hh=8'h01, pm=1.
  - Then press mode twice → one `load` pulse with `load_hh`=8'h01, `load_mm`=8'h30, `load_pm`=1.
- **Minute wrap:** cur 05:58, in SET_MM press inc ×3 → `load_mm` reaches 8'h01 and `load_hh` stays 8'h05 (no carry).
- **Simultaneous edges and held button:**
  - In SET_HH, assert both buttons in the same cycle → `mode`=2 and hh unchanged.
  - Hold `btn_inc` for 10 cycles in SET_MM → exactly one increment.
- **Freeze and invalid capture:**
  - During SET states, `tick_ena` stays 0 for >3×TICK_DIV cycles.
  - A capture with `cur_hh`=8'h00 yields shadow hh=8'h12.
- **Reset mid-set:** reset asserted in SET_MM after edits → `load` stays 0, `mode`=0, `load_hh`=8'h12, and the prescaler restarts (first tick at cycle TICK_DIV-1).
